// File: rtl/pdm_decoder_pkg.sv
// Shared constants and types for the PDM receive path.
// The CIC register width follows from the order and the decimation ratio.
package pdm_decoder_pkg;

  localparam int CIC_ORDER      = 3;
  localparam int PDM_DECIMATION = 256;

  typedef logic [15:0] amplitude;

  // Bit growth of an order-N CIC at ratio R is N*log2(R); one extra bit holds exact full scale.
  function automatic int cic_acc_bits(input int decimation);
    return CIC_ORDER * $clog2(decimation) + 1;
  endfunction

endpackage

// File: rtl/pdm_decoder.sv
// 1-bit PDM to unsigned PCM converter: CIC integrators at CLOCK_50, combs at CLOCK_50/DECIMATION.
// Output is the top bits of the comb result, saturated at exact full scale.
module pdm_decoder
  import pdm_decoder_pkg::*;
#(
  parameter int DECIMATION = PDM_DECIMATION,
  parameter int OUT_BITS   = $bits(amplitude)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                din,
  output logic [OUT_BITS-1:0] out,
  output logic                out_valid
);

  localparam int ACC_BITS  = cic_acc_bits(DECIMATION);
  localparam int CNT_BITS  = $clog2(DECIMATION);
  localparam int WARM_DONE = CIC_ORDER + 1;

  typedef logic [ACC_BITS-1:0] acc_t;

  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]          warm_q, warm_d;
  logic [OUT_BITS-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                dec_strobe;
  acc_t                x;

  // Bit ACC_BITS-1 is only reachable at exact full scale, which maps to all-ones.
  function automatic logic [OUT_BITS-1:0] scale_out(input acc_t c);
    logic [ACC_BITS+OUT_BITS-2:0] wide;
    wide = {c[ACC_BITS-2:0], {OUT_BITS{1'b0}}};
    if (c[ACC_BITS-1]) return '1;
    return OUT_BITS'(wide >> (ACC_BITS - 1));
  endfunction

  assign x = {{(ACC_BITS-1){1'b0}}, din};

  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_stage
    acc_t integ_q, integ_d;
    acc_t delay_q, delay_d;
    acc_t integ_in, comb_in, comb;

    if (k == 0) begin : g_first
      assign integ_in = x;
      assign comb_in  = g_stage[CIC_ORDER-1].integ_q;
    end else begin : g_rest
      assign integ_in = g_stage[k-1].integ_q;
      assign comb_in  = g_stage[k-1].comb;
    end

    always_comb begin
      integ_d = enable ? integ_q + integ_in : integ_q;
      comb    = comb_in - delay_q;
      delay_d = dec_strobe ? comb_in : delay_q;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        integ_q <= '0;
        delay_q <= '0;
      end else begin
        integ_q <= integ_d;
        delay_q <= delay_d;
      end
    end
  end

  always_comb begin
    dec_strobe  = enable && (cnt_q == CNT_BITS'(DECIMATION - 1));
    cnt_d       = enable ? cnt_q + CNT_BITS'(1) : cnt_q;
    warm_d      = warm_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (dec_strobe) begin
      // Samples during warm-up still update out, only the strobe is held back.
      if (warm_q != 3'(WARM_DONE)) warm_d = warm_q + 3'd1;
      out_d       = scale_out(g_stage[CIC_ORDER-1].comb);
      out_valid_d = (warm_q == 3'(WARM_DONE));
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      warm_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      warm_q      <= warm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
